// File: rtl/aes_pkg.sv
// Shared AES-256 key-schedule types, constants and the round-constant lookup.
package aes_pkg;
  localparam int NK = 8;
  localparam int NR = 14;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;
  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [0:6][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  // Rcon is only consumed on even round indices; idx/2 of 7 (idx 14) maps to zero.
  function automatic word_t rcon_word(input logic [3:0] idx);
    logic [2:0] i;
    i = idx[3:1];
    rcon_word = '0;
    if (i < 3'd7) rcon_word = {RCON[i], 24'h0};
  endfunction
endpackage

// File: rtl/aes_256_key_expand_if.sv
// Key-load and round-key handshake bundle between key source, expander and cipher.
interface aes_256_key_expand_if import aes_pkg::*; ();
  logic [32*NK-1:0] key;
  logic             key_valid;
  logic             key_ready;
  block_t           round_key;
  logic             rk_valid;
  logic             rk_ready;
  logic [3:0]       rk_idx;
  logic             done;

  modport master (output key, key_valid, rk_ready,
                  input  key_ready, round_key, rk_valid, rk_idx, done);
  modport slave  (input  key, key_valid, rk_ready,
                  output key_ready, round_key, rk_valid, rk_idx, done);
endinterface

// File: rtl/aes_sub_word.sv
// Combinational AES S-box applied to each byte of a 32-bit word.
module aes_sub_word import aes_pkg::*; (
  input  word_t din,
  output word_t dout
);
  localparam logic [0:255][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign dout[8*i +: 8] = SBOX[din[8*i +: 8]];
  end
endmodule

// File: rtl/aes_256_key_expand.sv
// AES-256 on-the-fly key expansion: a sliding 256-bit window {A,B} emits one 128-bit round key per beat.
// Optional macro AES_KEYEXP_ZEROIZE_EN clears the window and round_key after the final round key.
module aes_256_key_expand import aes_pkg::*; (
  input logic            enable,
  input logic            reset,
  aes_256_key_expand_if.slave kif
);
  state_t     state_q, state_d;
  block_t     a_q, a_d, b_q, b_d;
  logic [3:0] idx_q, idx_d;
  logic       done_q, done_d;

  word_t  b_w3, sub_in, sub_out, rc;
  block_t nxt;

  // Odd indices skip RotWord/Rcon: that is the extra SubWord step unique to the 8-word schedule.
  assign b_w3   = b_q[31:0];
  assign sub_in = idx_q[0] ? b_w3 : {b_w3[23:0], b_w3[31:24]};
  assign rc     = idx_q[0] ? '0 : rcon_word(idx_q);

  aes_sub_word u_sub (.din(sub_in), .dout(sub_out));

  assign nxt[127:96] = a_q[127:96] ^ sub_out ^ rc;
  assign nxt[95:64]  = a_q[95:64]  ^ nxt[127:96];
  assign nxt[63:32]  = a_q[63:32]  ^ nxt[95:64];
  assign nxt[31:0]   = a_q[31:0]   ^ nxt[63:32];

  assign kif.key_ready = (state_q == IDLE);
  assign kif.rk_valid  = (state_q == EMIT);
  assign kif.round_key = a_q;
  assign kif.rk_idx    = idx_q;
  assign kif.done      = done_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (kif.key_valid) begin
        a_d     = kif.key[255:128];
        b_d     = kif.key[127:0];
        idx_d   = '0;
        state_d = EMIT;
      end
      EMIT: if (kif.rk_ready) begin
        a_d = b_q;
        b_d = nxt;
        if (idx_q == 4'(NR)) begin
          state_d = IDLE;
          done_d  = 1'b1;
`ifdef AES_KEYEXP_ZEROIZE_EN
          a_d = '0;
          b_d = '0;
`endif
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge enable or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_aes_256_key_expand.sv
// Directed bench for aes_256_key_expand using FIPS-197 AES-256 key-schedule vectors.
module tb_aes_256_key_expand;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  localparam logic [255:0] K1 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K1_R0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] K1_R1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K1_R2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] K1_R14 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [255:0] K2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] K2_R0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] K2_R2  = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] K2_R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  aes_256_key_expand_if kif ();

  aes_256_key_expand dut (.enable(clk), .reset(rst_n), .kif(kif.slave));

  always #5 clk = ~clk;

  // Presents a key for one cycle; returns on the negedge where idx0 should be visible.
  task automatic load_key(input logic [255:0] k);
    @(negedge clk);
    kif.key = k;
    kif.key_valid = 1'b1;
    @(negedge clk);
    kif.key_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    kif.rk_ready = 1'b1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (kif.done === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL %s_timeout done never seen", name); end
  endtask

  task automatic test_reset;
    kif.key = '0; kif.key_valid = 1'b0; kif.rk_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    total++;
    if ({kif.rk_valid, kif.done, kif.rk_idx} !== 6'd0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0", {kif.rk_valid, kif.done, kif.rk_idx});
    end
    total++;
    if (kif.round_key !== 128'd0) begin bad++; $display("FAIL reset_rk got=%h exp=0", kif.round_key); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (kif.key_ready !== 1'b1 || kif.rk_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release key_ready=%b rk_valid=%b exp=1/0", kif.key_ready, kif.rk_valid);
    end
  endtask

  task automatic test_vec1;
    kif.rk_ready = 1'b1;
    load_key(K1);
    total++;
    if (kif.rk_valid !== 1'b1 || kif.key_ready !== 1'b0) begin
      bad++; $display("FAIL v1_latency rk_valid=%b key_ready=%b exp=1/0", kif.rk_valid, kif.key_ready);
    end
    total++;
    if (kif.rk_idx !== 4'd0 || kif.round_key !== K1_R0) begin
      bad++; $display("FAIL v1_idx0 got=%0d/%h exp=0/%h", kif.rk_idx, kif.round_key, K1_R0);
    end
    @(negedge clk);
    total++;
    if (kif.rk_idx !== 4'd1 || kif.round_key !== K1_R1) begin
      bad++; $display("FAIL v1_idx1 got=%0d/%h exp=1/%h", kif.rk_idx, kif.round_key, K1_R1);
    end
    @(negedge clk);
    total++;
    if (kif.rk_idx !== 4'd2 || kif.round_key !== K1_R2) begin
      bad++; $display("FAIL v1_idx2 got=%0d/%h exp=2/%h", kif.rk_idx, kif.round_key, K1_R2);
    end
    for (int i = 3; i <= 14; i++) begin
      @(negedge clk);
      total++;
      if (kif.rk_idx !== 4'(i) || kif.rk_valid !== 1'b1 || kif.done !== 1'b0) begin
        bad++; $display("FAIL v1_seq got=%0d/%b/%b exp=%0d/1/0", kif.rk_idx, kif.rk_valid, kif.done, i);
      end
    end
    total++;
    if (kif.round_key !== K1_R14) begin bad++; $display("FAIL v1_idx14 got=%h exp=%h", kif.round_key, K1_R14); end
    @(negedge clk);
    total++;
    if (kif.done !== 1'b1 || kif.rk_valid !== 1'b0 || kif.key_ready !== 1'b1 || kif.rk_idx !== 4'd14) begin
      bad++; $display("FAIL v1_done got=%b/%b/%b/%0d exp=1/0/1/14", kif.done, kif.rk_valid, kif.key_ready, kif.rk_idx);
    end
    @(negedge clk);
    total++;
    if (kif.done !== 1'b0) begin bad++; $display("FAIL v1_done_pulse got=%b exp=0", kif.done); end
  endtask

  task automatic test_vec2;
    kif.rk_ready = 1'b1;
    load_key(K2);
    total++;
    if (kif.round_key !== K2_R0) begin bad++; $display("FAIL v2_idx0 got=%h exp=%h", kif.round_key, K2_R0); end
    @(negedge clk);
    total++;
    if (kif.round_key !== K2_R1) begin bad++; $display("FAIL v2_idx1 got=%h exp=%h", kif.round_key, K2_R1); end
    @(negedge clk);
    total++;
    if (kif.round_key !== K2_R2) begin bad++; $display("FAIL v2_idx2 got=%h exp=%h", kif.round_key, K2_R2); end
    repeat (12) @(negedge clk);
    total++;
    if (kif.rk_idx !== 4'd14 || kif.round_key !== K2_R14) begin
      bad++; $display("FAIL v2_idx14 got=%0d/%h exp=14/%h", kif.rk_idx, kif.round_key, K2_R14);
    end
    wait_done("v2");
  endtask

  task automatic test_stall;
    int exp_idx;
    bit fin, stalled, known, go;
    logic [127:0] prev_rk, exp_rk;
    kif.rk_ready = 1'b0;
    load_key(K1);
    exp_idx = 0; fin = 0; stalled = 0; prev_rk = '0;
    for (int c = 0; c < 400 && !fin; c++) begin
      total++;
      if (kif.rk_idx !== 4'(exp_idx) || kif.rk_valid !== 1'b1 || kif.done !== 1'b0) begin
        bad++; $display("FAIL stall_idx got=%0d/%b/%b exp=%0d/1/0", kif.rk_idx, kif.rk_valid, kif.done, exp_idx);
      end
      if (stalled) begin
        total++;
        if (kif.round_key !== prev_rk) begin bad++; $display("FAIL stall_hold got=%h exp=%h", kif.round_key, prev_rk); end
      end
      known = 1;
      case (exp_idx)
        0: exp_rk = K1_R0;
        1: exp_rk = K1_R1;
        2: exp_rk = K1_R2;
        14: exp_rk = K1_R14;
        default: begin known = 0; exp_rk = '0; end
      endcase
      if (known) begin
        total++;
        if (kif.round_key !== exp_rk) begin
          bad++; $display("FAIL stall_val idx=%0d got=%h exp=%h", exp_idx, kif.round_key, exp_rk);
        end
      end
      prev_rk = kif.round_key;
      go = 1'($urandom_range(0, 1));
      kif.rk_ready = go;
      stalled = !go;
      @(negedge clk);
      if (go) begin
        if (exp_idx == 14) fin = 1;
        else exp_idx++;
      end
    end
    total++;
    if (!fin) begin bad++; $display("FAIL stall_timeout idx=%0d exp=done", exp_idx); end
    total++;
    if (kif.done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", kif.done); end
    kif.rk_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    kif.rk_ready = 1'b1;
    load_key(K1);
    repeat (7) @(negedge clk);
    total++;
    if (kif.rk_idx !== 4'd7) begin bad++; $display("FAIL mid_pre got=%0d exp=7", kif.rk_idx); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({kif.rk_valid, kif.done, kif.rk_idx} !== 6'd0 || kif.round_key !== 128'd0) begin
      bad++; $display("FAIL mid_reset got=%b/%h exp=0/0", {kif.rk_valid, kif.done, kif.rk_idx}, kif.round_key);
    end
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (kif.key_ready !== 1'b1) begin bad++; $display("FAIL mid_key_ready got=%b exp=1", kif.key_ready); end
    load_key(K2);
    total++;
    if (kif.rk_idx !== 4'd0 || kif.round_key !== K2_R0) begin
      bad++; $display("FAIL mid_reload0 got=%0d/%h exp=0/%h", kif.rk_idx, kif.round_key, K2_R0);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (kif.round_key !== K2_R2) begin bad++; $display("FAIL mid_reload2 got=%h exp=%h", kif.round_key, K2_R2); end
    wait_done("mid");
  endtask

  task automatic test_ignore_key;
    kif.rk_ready = 1'b1;
    load_key(K1);
    kif.key = K2;
    kif.key_valid = 1'b1;
    @(negedge clk);
    total++;
    if (kif.round_key !== K1_R1) begin bad++; $display("FAIL ign_idx1 got=%h exp=%h", kif.round_key, K1_R1); end
    @(negedge clk);
    total++;
    if (kif.round_key !== K1_R2) begin bad++; $display("FAIL ign_idx2 got=%h exp=%h", kif.round_key, K1_R2); end
    repeat (12) @(negedge clk);
    total++;
    if (kif.rk_idx !== 4'd14 || kif.round_key !== K1_R14 || kif.key_ready !== 1'b0) begin
      bad++; $display("FAIL ign_idx14 got=%0d/%h/%b exp=14/%h/0", kif.rk_idx, kif.round_key, kif.key_ready, K1_R14);
    end
    @(negedge clk);
    total++;
    if (kif.done !== 1'b1 || kif.key_ready !== 1'b1) begin
      bad++; $display("FAIL ign_done got=%b/%b exp=1/1", kif.done, kif.key_ready);
    end
    // key_valid still high: the done cycle is the earliest legal acceptance
    @(negedge clk);
    kif.key_valid = 1'b0;
    total++;
    if (kif.rk_valid !== 1'b1 || kif.rk_idx !== 4'd0 || kif.round_key !== K2_R0 || kif.done !== 1'b0) begin
      bad++; $display("FAIL ign_reaccept got=%b/%0d/%h exp=1/0/%h", kif.rk_valid, kif.rk_idx, kif.round_key, K2_R0);
    end
    wait_done("ign");
  endtask

  initial begin
    test_reset();
    test_vec1();
    test_vec2();
    test_stall();
    test_reset_mid();
    test_ignore_key();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
